// File: rtl/adc_sample_packer.sv
// Packs pairs of 12-bit ADC samples into tagged 32-bit words, groups them into
// fixed-length frames and streams them out of a first-word-fall-through FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for capture_en & sample_valid to take sample 0
// S_ACTIVE | accepting samples 1 .. FRAME_SAMPLES-1 of the current frame
module adc_sample_packer #(
    parameter int          DATA_WIDTH    = 12,
    parameter int          FRAME_SAMPLES = 256,
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [3:0]  CHANNEL_ID    = 4'h0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic                  capture_en,
    input  logic                  clear_status,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [15:0]           frames_done,
    output logic [15:0]           overflow_count,
    output logic                  overflow_flag
);

    localparam int CW = $clog2(FRAME_SAMPLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] REM_START = CW'(FRAME_SAMPLES - 1);
    localparam logic [CW-1:0] REM_ONE   = CW'(1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         rem, rem_nxt;
    logic                  accept, odd_sample, last_sample;

    logic [DATA_WIDTH-1:0] half;
    logic [3:0]            widx;
    logic                  wr_pend, wr_last, wr_user;
    logic [31:0]           wr_word;

    logic [33:0]           mem [FIFO_DEPTH];
    logic [AW:0]           wptr, rptr;
    logic [33:0]           head;
    logic                  empty, full, do_write, do_drop, do_read;

    // rem counts samples still owed to the frame; its parity marks odd samples
    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        accept      = 1'b0;
        odd_sample  = 1'b0;
        last_sample = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_valid && capture_en) begin
                    accept    = 1'b1;
                    rem_nxt   = REM_START;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (sample_valid) begin
                    accept      = 1'b1;
                    odd_sample  = rem[0];
                    last_sample = (rem == REM_ONE);
                    rem_nxt     = rem - CW'(1);
                    if (last_sample) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            half    <= '0;
            widx    <= '0;
            wr_pend <= 1'b0;
            wr_last <= 1'b0;
            wr_user <= 1'b0;
            wr_word <= '0;
        end else begin
            wr_pend <= accept && odd_sample;
            if (accept && !odd_sample) half <= sample_in;
            if (accept && odd_sample) begin
                wr_word <= {CHANNEL_ID, widx, half, sample_in};
                wr_last <= last_sample;
                wr_user <= (rem == REM_START);
                widx    <= last_sample ? 4'd0 : widx + 4'd1;
            end
        end
    end

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_write = wr_pend && !full;
    assign do_drop  = wr_pend && full;
    assign do_read  = !empty && m_axis_tready;

    always_ff @(posedge clk) begin
        if (do_write) mem[wptr[AW-1:0]] <= {wr_last, wr_user, wr_word};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) wptr <= wptr + 1'b1;
            if (do_read)  rptr <= rptr + 1'b1;
        end
    end

    assign head          = mem[rptr[AW-1:0]];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 32'd0 : head[31:0];
    assign m_axis_tuser  = !empty && head[32];
    assign m_axis_tlast  = !empty && head[33];
    assign busy          = (state == S_ACTIVE);

    // A dropped tlast word still closes its frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frames_done    <= '0;
            overflow_count <= '0;
            overflow_flag  <= 1'b0;
        end else begin
            if (wr_pend && wr_last) frames_done <= frames_done + 16'd1;
            if (do_drop) begin
                overflow_flag <= 1'b1;
                if (clear_status)
                    overflow_count <= 16'd1;
                else if (overflow_count != 16'hFFFF)
                    overflow_count <= overflow_count + 16'd1;
            end else if (clear_status) begin
                overflow_count <= '0;
                overflow_flag  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Bench for adc_sample_packer: a queue-based frame/FIFO model checked every
// cycle, plus directed scenarios pinned with hand-computed words.
module tb_adc_sample_packer;

    localparam int         F  = 40;
    localparam int         D  = 8;
    localparam logic [3:0] CH = 4'h5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        capture_en = 1'b0;
    logic        clear_status = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, overflow_flag;
    logic [15:0] frames_done, overflow_count;

    adc_sample_packer #(
        .DATA_WIDTH(12), .FRAME_SAMPLES(F), .FIFO_DEPTH(D), .CHANNEL_ID(CH)
    ) dut (
        .clk(clk), .rstn(rstn), .sample_in(sample_in), .sample_valid(sample_valid),
        .capture_en(capture_en), .clear_status(clear_status),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .busy(busy), .frames_done(frames_done),
        .overflow_count(overflow_count), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: FIFO as a queue, words built from sample index arithmetic
    logic [33:0] q[$];
    bit          m_in_frame = 0;
    int          m_n = 0;
    logic [11:0] m_held = '0;
    bit          m_pend = 0;
    logic [33:0] m_pend_word = '0;
    int          m_frames = 0;
    int          m_ovf = 0;
    bit          m_flag = 0;

    always @(posedge clk or negedge rstn) begin : model
        bit pop, full, drop, acc, npend;
        logic [33:0] nw;
        int idx;
        if (!rstn) begin
            q.delete();
            m_in_frame = 0; m_n = 0; m_held = '0; m_pend = 0; m_pend_word = '0;
            m_frames = 0; m_ovf = 0; m_flag = 0;
        end else begin
            pop  = (q.size() > 0) && m_axis_tready;
            full = (q.size() == D);
            drop = 0;
            if (pop) void'(q.pop_front());
            if (m_pend) begin
                if (full) drop = 1;
                else q.push_back(m_pend_word);
                if (m_pend_word[33]) m_frames++;
            end
            if (drop) begin
                m_flag = 1;
                if (clear_status) m_ovf = 1;
                else if (m_ovf < 65535) m_ovf++;
            end else if (clear_status) begin
                m_ovf = 0; m_flag = 0;
            end
            acc   = sample_valid && (m_in_frame || capture_en);
            npend = 0;
            nw    = '0;
            if (acc) begin
                idx = m_n;
                if (idx % 2 == 0) m_held = sample_in;
                else begin
                    npend = 1;
                    nw = {(idx == F - 1), (idx == 1), CH, 4'((idx / 2) % 16), m_held, sample_in};
                end
                m_n++;
                if (m_n == F) begin m_n = 0; m_in_frame = 0; end
                else m_in_frame = 1;
            end
            m_pend      = npend;
            m_pend_word = nw;
        end
    end

    bit tv_armed = 0;
    bit tv_seen  = 0;
    int tv_cyc   = 0;

    always @(negedge clk) begin
        chk("tvalid", m_axis_tvalid, q.size() > 0);
        if (q.size() > 0) begin
            chk("tdata", m_axis_tdata, q[0][31:0]);
            chk("tuser", m_axis_tuser, q[0][32]);
            chk("tlast", m_axis_tlast, q[0][33]);
        end
        chk("busy", busy, m_in_frame);
        chk("frames_done", frames_done, 16'(m_frames));
        chk("overflow_count", overflow_count, 16'(m_ovf));
        chk("overflow_flag", overflow_flag, m_flag);
        if (tv_armed && !tv_seen && m_axis_tvalid) begin
            tv_seen = 1;
            tv_cyc  = cyc;
        end
    end

    logic [33:0] rx[$];
    always @(posedge clk) begin
        if (rstn && m_axis_tvalid && m_axis_tready)
            rx.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end

    function automatic int count_last();
        int c = 0;
        foreach (rx[i]) if (rx[i][33]) c++;
        return c;
    endfunction

    task automatic step(input bit v, input logic [11:0] d, input bit ce, input bit rdy, input bit clr);
        sample_valid  = v;
        sample_in     = d;
        capture_en    = ce;
        m_axis_tready = rdy;
        clear_status  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 12'h0, 0, rdy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s2_cyc;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_frames", frames_done, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_busy", busy, 0);

        // continuous valid, incrementing samples, always ready
        rx.delete();
        tv_armed = 1;
        s2_cyc = 0;
        for (int i = 1; i <= F; i++) begin
            if (i == 2) s2_cyc = cyc;
            step(1, 12'(i), 1, 1, 0);
        end
        idle(5, 1);
        chk("A_latency", tv_seen ? tv_cyc - s2_cyc : -1, 2);
        chk("A_words", rx.size(), 20);
        if (rx.size() == 20) begin
            chk("A_w0", rx[0][31:0], 32'h5000_1002);
            chk("A_w0_user", rx[0][32], 1);
            chk("A_w1", rx[1][31:0], 32'h5100_3004);
            chk("A_w16_wrap", rx[16][31:0], 32'h5002_1022);
            chk("A_w19", rx[19][31:0], 32'h5302_7028);
            chk("A_w19_last", rx[19][33], 1);
        end
        chk("A_nlast", count_last(), 1);
        chk("A_frames", frames_done, 1);

        // whole frame with tready low: FIFO fills, rest dropped
        for (int i = 1; i <= F; i++) step(1, 12'(i + 256), i == 1, 0, 0);
        idle(3, 0);
        chk("C_ovf", overflow_count, 12);
        chk("C_flag", overflow_flag, 1);
        chk("C_frames", frames_done, 2);
        rx.delete();
        idle(20, 1);
        chk("C_drain", rx.size(), 8);
        if (rx.size() == 8) begin
            chk("C_d0", rx[0][31:0], 32'h5010_1102);
            chk("C_d0_user", rx[0][32], 1);
            chk("C_d7", rx[7][31:0], 32'h5710_F110);
        end
        chk("C_nlast", count_last(), 0);

        step(0, 12'h0, 0, 1, 1);
        chk("clr_alone_ovf", overflow_count, 0);
        chk("clr_alone_flag", overflow_flag, 0);

        // clear_status on the same edge as the first drop
        for (int i = 1; i <= 18; i++) step(1, 12'(i + 512), i == 1, 0, 0);
        step(1, 12'(19 + 512), 0, 0, 1);
        chk("clr_drop_ovf", overflow_count, 1);
        chk("clr_drop_flag", overflow_flag, 1);
        step(1, 12'(20 + 512), 0, 1, 1);
        chk("clr_after_ovf", overflow_count, 0);
        chk("clr_after_flag", overflow_flag, 0);
        for (int i = 21; i <= F; i++) step(1, 12'(i + 512), 0, 1, 0);
        idle(20, 1);

        // capture_en dropped after sample 1; frame still completes
        for (int i = 1; i <= F; i++) begin
            step(1, 12'($urandom), i <= 2, 1, 0);
            if (i == F - 1) chk("D_busy_mid", busy, 1);
        end
        chk("D_busy_end", busy, 0);
        for (int i = 0; i < 6; i++) step(1, 12'($urandom), 0, 1, 0);
        idle(4, 1);
        chk("D_busy_ignored", busy, 0);
        chk("D_no_output", m_axis_tvalid, 0);

        // reset mid-frame after sample 0x001
        step(1, 12'h001, 1, 1, 0);
        rstn = 1'b0;
        idle(2, 1);
        rstn = 1'b1;
        idle(4, 1);
        chk("E_tvalid", m_axis_tvalid, 0);
        chk("E_frames", frames_done, 0);
        chk("E_busy", busy, 0);
        rx.delete();
        for (int i = 1; i <= F; i++) step(1, 12'(i), i == 1, 1, 0);
        idle(5, 1);
        chk("E_words", rx.size(), 20);
        if (rx.size() > 0) begin
            chk("E_w0", rx[0][31:0], 32'h5000_1002);
            chk("E_w0_user", rx[0][32], 1);
        end

        // strict 1-in-3 valid, random data, always ready
        for (int i = 0; i < 3 * F * 2; i++) step(i % 3 == 0, 12'($urandom), 1, 1, 0);
        idle(10, 1);

        // fully randomized traffic with phases of heavy backpressure
        for (int blk = 0; blk < 12; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 3 == 0) ? 10 : 80;
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 2) != 0, 12'($urandom), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 63) == 0);
        end
        idle(40, 1);
        chk("final_empty", m_axis_tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_packer.md
Name: adc_sample_packer

Overview:
Downstream of the AD9228 gearbox, in the dco_div4 clock domain. Takes 12-bit samples qualified by a valid strobe, packs pairs of samples into 32-bit tagged words and groups them into fixed-length frames. Frames are buffered in a small FIFO and presented on an AXI4-Stream master toward the DMA/readout path. Includes overflow accounting and frame counters for the control board status registers.

Parameters:
DATA_WIDTH, 12, sample width; must be 12 (packing format is fixed).
FRAME_SAMPLES, 256, samples per frame; even, >= 4.
FIFO_DEPTH, 16, output FIFO depth in 32-bit words; power of two, >= 4.
CHANNEL_ID, 4'h0, 4-bit channel tag inserted in every word.

Ports:
clk  in  1  dco_div4 clock; same clock as the gearbox output.
rstn  in  1  Reset: asynchronous, active-low.
sample_in  in  DATA_WIDTH  sample from gearbox data_out.
sample_valid  in  1  qualifies sample_in for one clk; may be high on any cycle pattern.
capture_en  in  1  enables frame capture; level, sampled only when IDLE.
clear_status  in  1  one-cycle pulse; clears overflow_count and overflow_flag.
m_axis_tdata  out  32  packed word.
m_axis_tvalid  out  1  AXIS valid.
m_axis_tready  in  1  AXIS ready.
m_axis_tlast  out  1  last word of frame.
m_axis_tuser  out  1  first word of frame.
busy  out  1  high while in ACTIVE.
frames_done  out  16  count of completed frames, wraps at 16'hFFFF->0.
overflow_count  out  16  words dropped due to FIFO full, saturating at 16'hFFFF.
overflow_flag  out  1  sticky, set on any drop.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; pair half-register and word index cleared. Reset mid-frame discards partial pair and all buffered words; no tlast emitted for the aborted frame.
- States: IDLE -> ACTIVE when capture_en=1 and sample_valid=1 on the same cycle; that sample is sample 0 of the frame. ACTIVE -> IDLE on the cycle the last sample (index FRAME_SAMPLES-1) is accepted. capture_en low during ACTIVE has no effect; frame always completes. Back-to-back frames: a valid sample on the cycle after returning to IDLE with capture_en=1 starts the next frame (no cycles lost except the transition cycle itself, which also accepts if both conditions hold).
- Samples with sample_valid=1 in IDLE and capture_en=0 are ignored.
- Packing: even-index sample held in half-register; on odd-index sample, word formed: [31:28]=CHANNEL_ID, [27:24]=word index within frame mod 16, [23:12]=even (older) sample, [11:0]=odd (newer) sample. tuser=1 for word index 0, tlast=1 for word index FRAME_SAMPLES/2-1; both stored in FIFO with the word.
- FIFO write on the cycle after odd sample accepted. First-word-fall-through: m_axis_tvalid high the cycle after the write into an empty FIFO. Write-to-output latency 2 clk from odd sample valid.
- AXIS: tdata/tlast/tuser stable while tvalid=1 and tready=0; transfer on tvalid&tready.
- Full: write rejected whenever FIFO full at write time, even if a read occurs same cycle. Rejected word dropped; word index still advances; overflow_count increments (saturating), overflow_flag set. Dropped tlast word still increments frames_done.
- frames_done increments when the tlast word is written or dropped.
- clear_status and a drop in the same cycle: result overflow_count=1, overflow_flag=1.
- Empty: tvalid=0; tready ignored.
- busy = (state==ACTIVE).

Test Plan:
- Reset, capture_en=1, sample_valid continuous, samples 0x001,0x002,..., tready=1, FRAME_SAMPLES=4 -> two words 0x0_0_001_002 (tuser=1), 0x0_1_003_004 (tlast=1); first tvalid 2 clk after sample 0x002; frames_done=1.
- Gapped valid (1 of 3 cycles), CHANNEL_ID=4'h5, FRAME_SAMPLES=256 -> 128 words, index field wraps F->0 at word 16, tlast only on word 127, tdata correct.
- tready=0 for whole 256-sample frame, FIFO_DEPTH=16 -> 16 words buffered, overflow_count=112, overflow_flag=1, frames_done=1; then tready=1 drains exactly 16 words, first has tuser=1, none has tlast.
- capture_en dropped after sample 1 of a 4-sample frame -> frame completes, tlast emitted, busy falls after sample 3, further samples ignored.
- rstn asserted after sample 0x001 mid-frame, released -> no output; next frame's first word tuser=1, index 0.
- clear_status pulse coincident with a drop -> overflow_count=1, flag=1; pulse alone -> both 0.
